// File: rtl/if_fetch_queue_if.sv
// Fetch-stage bus bundle: instruction memory port, redirect input and decode handshake.
interface if_fetch_queue_if;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  modport master (
    output imem_read, imem_address, instr_valid, instr, instr_pc,
    input  imem_rdata, imem_resp, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_read, imem_address, instr_valid, instr, instr_pc,
    output imem_rdata, imem_resp, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: single-outstanding imem reads feeding a small {word, pc} FIFO
// towards decode, with flush-and-restart on redirect.
module if_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h6000_0000
) (
  input logic              clk,
  input logic              rst,
  if_fetch_queue_if.master bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } entry_t;

  state_t           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      addr_q, addr_d;
  logic             read_q;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q;
  entry_t           head_q, head_d;
  entry_t           mem_q [DEPTH];

  logic             push, pop, space;
  logic [31:0]      target_pc;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^bus.redirect_pc[1:0];

  // FIFO bookkeeping, fetch FSM and next values of every registered output.
  always_comb begin
    pop       = valid_q & bus.instr_ready;
    push      = bus.imem_resp & (state_q == WAIT) & ~bus.redirect;
    target_pc = {bus.redirect_pc[31:2], 2'b00};

    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (bus.redirect) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
    space = count_d < CNT_W'(DEPTH);

    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      IDLE: begin
        if (bus.redirect)  fetch_pc_d = target_pc;
        else if (space)    state_d    = WAIT;
      end
      WAIT: begin
        if (bus.redirect) begin
          fetch_pc_d = target_pc;
          state_d    = bus.imem_resp ? IDLE : DISCARD;
        end else if (bus.imem_resp) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = space ? WAIT : IDLE;
        end
      end
      DISCARD: begin
        if (bus.redirect)  fetch_pc_d = target_pc;
        if (bus.imem_resp) state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The in-flight read keeps its address while fetch_pc already holds the redirect target.
    addr_d = (state_d == DISCARD) ? addr_q : fetch_pc_d;

    // Head bypass: a word pushed into an empty (or emptying) FIFO becomes the head directly.
    head_d = mem_q[rd_ptr_d];
    if (push && (wr_ptr_q == rd_ptr_d)) begin
      head_d.word = bus.imem_rdata;
      head_d.pc   = fetch_pc_q;
    end
    if (count_d == '0) head_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      read_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      head_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      read_q     <= (state_d != IDLE);
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      valid_q    <= (count_d != '0);
      head_q     <= head_d;
    end
  end

  // Entry storage; only read where the count says it holds live data.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q].word <= bus.imem_rdata;
      mem_q[wr_ptr_q].pc   <= fetch_pc_q;
    end
  end

  assign bus.imem_read    = read_q;
  assign bus.imem_address = addr_q;
  assign bus.instr_valid  = valid_q;
  assign bus.instr        = head_q.word;
  assign bus.instr_pc     = head_q.pc;
endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized bench for if_fetch_queue: a memory/redirect driver feeds a scoreboard of
// expected {pc, word} deliveries, and a separate monitor checks the decode side against it.
module tb_if_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h6000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;

  if_fetch_queue_if bus ();

  if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          delivered = 0;

  // Reference fetch model state
  bit          outstanding = 0;
  bit          stale = 0;
  logic [31:0] req_addr = '0;
  logic [31:0] model_pc = RESET_PC;
  int          lat = 0;
  int          idle_cnt = 0;

  // Stimulus knobs
  int          lat_min = 0, lat_max = 0, ready_pct = 100, redir_pct = 0;
  bit          nop_mem = 1;
  bit          force_rd = 0;
  logic [31:0] force_rpc = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a, input bit nop);
    if (nop) return 32'h0000_0013;
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check_reset_outputs();
    check("rst_imem_read", 32'(bus.imem_read), 32'd0);
    check("rst_imem_address", bus.imem_address, RESET_PC);
    check("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_instr", bus.instr, 32'd0);
    check("rst_instr_pc", bus.instr_pc, 32'd0);
  endtask

  // One clock cycle of memory/redirect/ready stimulus plus the fetch-side checks.
  task automatic step();
    bit          rd_now, resp_now;
    logic [31:0] rpc;
    exp_t        e;
    @(negedge clk);
    cyc++;
    if (outstanding) begin
      check("req_hold_read", 32'(bus.imem_read), 32'd1);
      check("req_hold_addr", bus.imem_address, req_addr);
    end else if (bus.imem_read) begin
      check("issue_with_space", 32'(exp_q.size() < DEPTH), 32'd1);
      check("fetch_addr", bus.imem_address, model_pc);
      outstanding = 1;
      stale       = 0;
      req_addr    = bus.imem_address;
      lat         = int'($urandom_range(lat_max, lat_min));
      idle_cnt    = 0;
    end else begin
      if (exp_q.size() < DEPTH) idle_cnt++;
      else idle_cnt = 0;
      check("fetch_stall", 32'(idle_cnt > 4), 32'd0);
    end

    rd_now = force_rd || ($urandom_range(99) < redir_pct);
    if (force_rd) rpc = force_rpc;
    else if ($urandom_range(15) == 0) rpc = 32'hFFFF_FFF0 | $urandom_range(15);
    else rpc = $urandom;
    force_rd = 0;

    resp_now = 0;
    if (outstanding) begin
      if (lat == 0) resp_now = 1;
      else lat--;
    end

    bus.imem_resp   = resp_now;
    bus.imem_rdata  = resp_now ? mem_word(req_addr, nop_mem) : $urandom;
    bus.redirect    = rd_now;
    bus.redirect_pc = rpc;
    bus.instr_ready = ($urandom_range(99) < ready_pct);

    if (rd_now) begin
      stale    = 1;
      idle_cnt = 0;
    end
    if (resp_now) begin
      if (!stale) begin
        e.pc   = req_addr;
        e.word = mem_word(req_addr, nop_mem);
        e.cyc  = cyc;
        exp_q.push_back(e);
        model_pc = req_addr + 32'd4;
      end
      outstanding = 0;
    end
    if (rd_now) model_pc = {rpc[31:2], 2'b00};
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Decode-side monitor: compares the head against the scoreboard every cycle.
  initial begin
    bit has_head;
    forever begin
      @(negedge clk);
      #1;
      has_head = (exp_q.size() > 0) && (exp_q[0].cyc < cyc);
      check("instr_valid", 32'(bus.instr_valid), 32'(has_head));
      if (has_head) begin
        check("instr", bus.instr, exp_q[0].word);
        check("instr_pc", bus.instr_pc, exp_q[0].pc);
      end else begin
        check("instr_empty", bus.instr, 32'd0);
        check("instr_pc_empty", bus.instr_pc, 32'd0);
      end
      if (bus.redirect) begin
        exp_q.delete();
      end else if (has_head && bus.instr_ready) begin
        void'(exp_q.pop_front());
        delivered++;
      end
    end
  end

  initial begin
    bus.imem_resp   = 1'b0;
    bus.imem_rdata  = '0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.instr_ready = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    cyc++;
    rst = 1'b1;
    check("first_cycle_idle", 32'(bus.imem_read), 32'd0);

    // Single-cycle memory, decode always ready: one fetch per cycle.
    lat_min = 0; lat_max = 0; ready_pct = 100; redir_pct = 0; nop_mem = 1;
    run(40);
    check("stream_throughput", 32'(delivered >= 35), 32'd1);

    // Decode stalled: FIFO fills to DEPTH and fetch stops, then drains.
    ready_pct = 0;
    run(12);
    check("buffered_words", 32'(exp_q.size()), 32'(DEPTH));
    check("read_stopped", 32'(bus.imem_read), 32'd0);
    ready_pct = 100;
    run(20);

    // 3-cycle memory with a redirect in the 2nd wait cycle.
    nop_mem = 0; lat_min = 2; lat_max = 2;
    for (int i = 0; i < 10 && !outstanding; i++) step();
    step();
    force_rd = 1; force_rpc = 32'h6000_0100;
    run(12);

    // Unaligned redirect target, then address wrap past 0xFFFFFFFC.
    force_rd = 1; force_rpc = 32'h6000_0102;
    run(8);
    lat_min = 0; lat_max = 0;
    force_rd = 1; force_rpc = 32'hFFFF_FFF5;
    run(10);

    // Random latency, ready and redirects.
    lat_min = 0; lat_max = 3; ready_pct = 50; redir_pct = 4;
    run(4000);

    // Asynchronous reset while a read is outstanding, with a stale response afterwards.
    redir_pct = 0; lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && !outstanding; i++) step();
    check("reached_wait", 32'(outstanding), 32'd1);
    @(negedge clk);
    cyc++;
    bus.imem_resp = 1'b0; bus.redirect = 1'b0; bus.instr_ready = 1'b0;
    #3 rst = 1'b0;
    #1;
    check_reset_outputs();
    exp_q.delete();
    outstanding = 0; stale = 0; model_pc = RESET_PC; idle_cnt = 0;
    @(negedge clk);
    cyc++;
    rst = 1'b1;
    check("release_idle", 32'(bus.imem_read), 32'd0);
    bus.imem_resp  = 1'b1;
    bus.imem_rdata = 32'hBAD0_BAD0;
    lat_min = 0; lat_max = 2; ready_pct = 80;
    run(40);

    check("total_delivered", 32'(delivered > 100), 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Instruction fetch stage directly upstream of the instruction decoder.
- Holds the fetch PC and issues single-outstanding reads to instruction memory.
- Buffers returned words with their PCs in a small FIFO and presents the head word to decode via a valid/ready handshake.
- Supports redirects from branch/jump resolution.

Parameters:
DEPTH, 4, number of FIFO entries (power of 2, >= 2)
RESET_PC, 32'h60000000, first fetch address after reset

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
imem_read  output  1  instruction memory read request
imem_address  output  32  word-aligned fetch address
imem_rdata  input  32  returned instruction word
imem_resp  input  1  read completes this cycle; imem_rdata valid
redirect  input  1  flush and restart fetch at redirect_pc
redirect_pc  input  32  new fetch PC; bits [1:0] ignored (forced 0)
instr_valid  output  1  FIFO head valid
instr  output  32  head instruction word; 32'h0 when empty
instr_pc  output  32  PC of head word; 32'h0 when empty
instr_ready  input  1  decode accepts head this cycle

Behaviour:
- Reset (rst low, async): state=IDLE, fetch_pc=RESET_PC, FIFO empty, count=0; imem_read=0, imem_address=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
- imem_read and imem_address are driven from registers only. No combinational path from imem_resp, redirect or instr_ready to imem_*.
- States:
  - IDLE: no request outstanding.
  - WAIT: request outstanding, response will be kept.
  - DISCARD: request outstanding, response will be dropped.
- imem_read=1 in WAIT and DISCARD. imem_address=fetch_pc, held stable until imem_resp.
- pop = instr_valid & instr_ready.
- push = imem_resp & state==WAIT & ~redirect. A push writes {imem_rdata, fetch_pc} at the tail.
- space = (count + push - pop) < DEPTH, evaluated on the next-cycle count.
- IDLE:
  - redirect: fetch_pc<=redirect_pc, stay IDLE.
  - else if count-pop < DEPTH: go WAIT.
- WAIT:
  - redirect & ~imem_resp: go DISCARD, fetch_pc<=redirect_pc.
  - redirect & imem_resp: word dropped, fetch_pc<=redirect_pc, go IDLE.
  - imem_resp & ~redirect: fetch_pc<=fetch_pc+4. Stay WAIT if space, else go IDLE. Back-to-back fetch allowed.
- DISCARD:
  - Read cannot be cancelled. Keep imem_read high at the old address until imem_resp.
  - On imem_resp: drop data, go IDLE. fetch_pc already holds the redirect target.
  - A further redirect in DISCARD overwrites fetch_pc and stays DISCARD.
  - In DISCARD, imem_address = address of the outstanding read, held in a separate req_addr register. fetch_pc holds the target.
- Redirect also flushes the FIFO the same cycle: count<=0, pointers reset. A pop in the same cycle is ignored. Redirect has priority over push and pop.
- Latency:
  - imem_resp in cycle t → instr_valid=1 in t+1 (FIFO empty case).
  - First imem_read=1 in the first cycle after rst deasserts.
- Full FIFO: no new request issues. An outstanding request always has a slot reserved, so a push is never lost.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged.
- Empty FIFO: pop is ignored; instr/instr_pc read 0.
- Pointers wrap modulo DEPTH. fetch_pc+4 wraps modulo 2^32.
- Reset mid-request: state returns to IDLE immediately. A late imem_resp in the first cycle after reset is ignored.

Test Plan:
- Reset, then single-cycle memory returning 32'h00000013 at every address, instr_ready=1 → imem_address sequence 0x60000000, 0x60000004, ... one per cycle; instr_pc follows one cycle behind.
- instr_ready=0 with single-cycle memory → exactly 4 words buffered (PCs 0x60000000..0x6000000C); imem_read=0 afterwards, instr_valid held, head stable. Raise ready → drains in order, fetch resumes at 0x60000010.
- 3-cycle memory latency, redirect to 0x60000100 in the 2nd wait cycle → imem_address stays at the old PC until resp; that word is not enqueued; next request targets 0x60000100; FIFO empty in the cycle after redirect.
- Redirect in the same cycle as imem_resp and instr_ready with 2 entries queued → nothing enqueued, count=0 next cycle, next fetch at redirect_pc.
- redirect_pc=32'h60000102 → fetch at 0x60000100. Fetch at 0xFFFFFFFC followed by the next fetch → address 0x00000000.
- Assert rst low while in WAIT → outputs go to reset values without a clock edge. After release, first request to RESET_PC and a stale imem_resp is ignored.
